// File: rtl/vdg_pkg.sv
// ============================================================================
// vdg_pkg : shared types, mode table, colours and window geometry for the VDG
// Rev 1.0
// ============================================================================
`default_nettype none

package vdg_pkg;

  localparam int unsigned WIN_H_BORDER = 64;
  localparam int unsigned WIN_V_BORDER = 48;
  localparam int unsigned WIN_W        = 512;
  localparam int unsigned WIN_H        = 384;
  localparam int unsigned TEXT_SUBROWS = 12;
  localparam int unsigned PIPE_LAT     = 5;

  localparam logic [8:0] COL_BLACK  = 9'b000000000;
  localparam logic [8:0] COL_GREEN  = 9'b000111000;
  localparam logic [8:0] COL_YELLOW = 9'b111111000;
  localparam logic [8:0] COL_BLUE   = 9'b000000111;
  localparam logic [8:0] COL_RED    = 9'b111000000;

  typedef enum logic {
    DISP_TEXT = 1'b0,
    DISP_GFX  = 1'b1
  } disp_e;

  typedef enum logic [2:0] {
    GM_64X64_C   = 3'd0,
    GM_128X64_M  = 3'd1,
    GM_128X64_C  = 3'd2,
    GM_128X96_M  = 3'd3,
    GM_128X96_C  = 3'd4,
    GM_128X192_M = 3'd5,
    GM_128X192_C = 3'd6,
    GM_256X192_M = 3'd7
  } gfx_mode_e;

  typedef struct packed {
    logic [5:0] bpr;
    logic [1:0] rep;
    logic [2:0] shift;
    logic       bpp2;
  } mode_cfg_t;

  localparam mode_cfg_t MODE_TABLE [8] = '{
    '{bpr: 6'd16, rep: 2'd3, shift: 3'd4, bpp2: 1'b1},
    '{bpr: 6'd16, rep: 2'd3, shift: 3'd4, bpp2: 1'b0},
    '{bpr: 6'd32, rep: 2'd3, shift: 3'd3, bpp2: 1'b1},
    '{bpr: 6'd16, rep: 2'd2, shift: 3'd4, bpp2: 1'b0},
    '{bpr: 6'd32, rep: 2'd2, shift: 3'd3, bpp2: 1'b1},
    '{bpr: 6'd16, rep: 2'd1, shift: 3'd4, bpp2: 1'b0},
    '{bpr: 6'd32, rep: 2'd1, shift: 3'd3, bpp2: 1'b1},
    '{bpr: 6'd32, rep: 2'd1, shift: 3'd3, bpp2: 1'b0}
  };

  typedef struct packed {
    logic       win;
    logic       text;
    logic       bpp2;
    logic [2:0] off;
  } pix_stage_t;

  // off is the MSB-first bit offset of the pixel inside the byte
  function automatic logic [8:0] pix_colour(input logic text, input logic bpp2,
                                            input logic [2:0] off, input logic [7:0] vbyte,
                                            input logic [7:0] cbyte, input logic [8:0] fg);
    logic [1:0] pair;
    logic [8:0] col;
    pair = {vbyte[3'd7 - off], vbyte[3'd6 - off]};
    col  = COL_BLACK;
    if (text) begin
      col = (cbyte[3'd7 - off] ^ vbyte[7]) ? fg : COL_BLACK;
    end else if (!bpp2) begin
      col = vbyte[3'd7 - off] ? fg : COL_BLACK;
    end else begin
      unique case (pair)
        2'b00:   col = COL_GREEN;
        2'b01:   col = COL_YELLOW;
        2'b10:   col = COL_BLUE;
        default: col = COL_RED;
      endcase
    end
    return col;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vdg_line_counter.sv
// ============================================================================
// vdg_line_counter : text sub-row/row and graphics repeat/row counters
// Rev 1.0
// ============================================================================
`default_nettype none

module vdg_line_counter import vdg_pkg::*; #(
  parameter int unsigned V_BORDER = WIN_V_BORDER
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  gfx_mode_e  mode,
  output logic [3:0] sr,
  output logic [3:0] tr,
  output logic [7:0] gr
);

  localparam logic [9:0] Y_LO = 10'(V_BORDER);
  localparam logic [9:0] Y_HI = 10'(V_BORDER + WIN_H);
  localparam logic [3:0] SR_LAST = 4'(TEXT_SUBROWS - 1);

  logic [1:0] rc;
  logic [1:0] rc_last;
  logic       advance;

  // Each logical line is two VGA lines; step at the start of the line that
  // follows an odd window line so both VGA lines share one counter value.
  always_comb begin
    rc_last = MODE_TABLE[mode].rep - 2'd1;
    advance = (y_in > Y_LO) && (y_in < Y_HI) && ((y_in[0] ^ Y_LO[0]) == 1'b0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
      tr <= '0;
      rc <= '0;
      gr <= '0;
    end else if (x_in == '0) begin
      if (y_in == Y_LO) begin
        sr <= '0;
        tr <= '0;
        rc <= '0;
        gr <= '0;
      end else if (advance) begin
        if (sr == SR_LAST) begin
          sr <= '0;
          tr <= tr + 4'd1;
        end else begin
          sr <= sr + 4'd1;
        end
        if (rc == rc_last) begin
          rc <= '0;
          gr <= gr + 8'd1;
        end else begin
          rc <= rc + 2'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vdg_pixel_pipe.sv
// ============================================================================
// vdg_pixel_pipe : 6847-style text/graphics fetch and format, 5-clock pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module vdg_pixel_pipe import vdg_pkg::*; #(
  parameter int unsigned H_BORDER = WIN_H_BORDER,
  parameter int unsigned V_BORDER = WIN_V_BORDER,
  parameter logic [8:0]  FG_GREEN = COL_GREEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  graphics_mode,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        active_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [12:0] vid_addr,
  input  logic [7:0]  vid_data,
  output logic [9:0]  chr_addr,
  input  logic [7:0]  chr_data,
  output logic [8:0]  rgb,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [9:0] X_LO = 10'(H_BORDER);
  localparam logic [9:0] X_HI = 10'(H_BORDER + WIN_W);
  localparam logic [9:0] Y_LO = 10'(V_BORDER);
  localparam logic [9:0] Y_HI = 10'(V_BORDER + WIN_H);

  logic [3:0]    mode_q;
  gfx_mode_e     gm;
  logic          is_text;
  logic          in_win;
  logic [7:0]    lx;
  logic [12:0]   addr;
  logic [2:0]    off;
  logic [3:0]    sr, tr;
  logic [7:0]    gr;
  pix_stage_t    pipe [1:4];
  logic [3:0]    sr_d [1:2];
  logic [7:0]    data3, data4;
  logic [PIPE_LAT-1:0] hs_d, vs_d;

  vdg_line_counter #(.V_BORDER(V_BORDER)) u_line_counter (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .y_in  (y_in),
    .mode  (gm),
    .sr    (sr),
    .tr    (tr),
    .gr    (gr)
  );

  always_comb begin
    gm      = gfx_mode_e'(mode_q[3:1]);
    is_text = (disp_e'(mode_q[0]) == DISP_TEXT);
    in_win  = active_in && (x_in >= X_LO) && (x_in < X_HI) && (y_in >= Y_LO) && (y_in < Y_HI);
    lx      = 8'((x_in - X_LO) >> 1);
    if (is_text) begin
      addr = {4'd0, tr, lx[7:3]};
      off  = lx[2:0];
    end else begin
      addr = 13'(gr) * 13'(MODE_TABLE[gm].bpr) + (13'(lx) >> MODE_TABLE[gm].shift);
      // Scale the in-byte logical position to a bit offset; 2bpp snaps to a pair.
      off  = 3'({lx, 3'b000} >> MODE_TABLE[gm].shift);
      if (MODE_TABLE[gm].bpp2) off[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= '0;
      vid_addr <= '0;
      chr_addr <= '0;
      rgb      <= '0;
      hs_d     <= '0;
      vs_d     <= '0;
      data3    <= '0;
      data4    <= '0;
      sr_d[1]  <= '0;
      sr_d[2]  <= '0;
      for (int i = 1; i <= 4; i++) pipe[i] <= '0;
    end else begin
      if (x_in == '0 && y_in == '0) mode_q <= graphics_mode;
      if (in_win) vid_addr <= addr;
      pipe[1] <= '{win: in_win, text: is_text, bpp2: MODE_TABLE[gm].bpp2, off: off};
      sr_d[1] <= sr;
      pipe[2] <= pipe[1];
      sr_d[2] <= sr_d[1];
      pipe[3] <= pipe[2];
      data3   <= vid_data;
      if (pipe[2].win) chr_addr <= {vid_data[5:0], sr_d[2]};
      pipe[4] <= pipe[3];
      data4   <= data3;
      rgb     <= pipe[4].win ? pix_colour(pipe[4].text, pipe[4].bpp2, pipe[4].off,
                                          data4, chr_data, FG_GREEN) : COL_BLACK;
      hs_d    <= {hs_d[PIPE_LAT-2:0], hs_in};
      vs_d    <= {vs_d[PIPE_LAT-2:0], vs_in};
    end
  end

  assign hsync = hs_d[PIPE_LAT-1];
  assign vsync = vs_d[PIPE_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_vdg_pixel_pipe.sv
// ============================================================================
// tb_vdg_pixel_pipe : directed self-checking bench for vdg_pixel_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vdg_pixel_pipe;

  localparam logic [8:0] BLK = 9'b000000000;
  localparam logic [8:0] GRN = 9'b000111000;
  localparam logic [8:0] YEL = 9'b111111000;
  localparam logic [8:0] BLU = 9'b000000111;
  localparam logic [8:0] RED = 9'b111000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  graphics_mode = 4'h0;
  logic [9:0]  x_in = '0;
  logic [9:0]  y_in = '0;
  logic        active_in = 1'b0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data = '0;
  logic [9:0]  chr_addr;
  logic [7:0]  chr_data = '0;
  logic [8:0]  rgb;
  logic        hsync;
  logic        vsync;

  logic [7:0]  ram [8192];
  logic [7:0]  rom [1024];
  logic [8:0]  cap [64];
  logic [12:0] va  [64];
  logic [9:0]  ca  [64];

  int checks = 0;
  int errors = 0;

  vdg_pixel_pipe dut (
    .clk           (clk),
    .reset         (reset),
    .graphics_mode (graphics_mode),
    .x_in          (x_in),
    .y_in          (y_in),
    .active_in     (active_in),
    .hs_in         (hs_in),
    .vs_in         (vs_in),
    .vid_addr      (vid_addr),
    .vid_data      (vid_data),
    .chr_addr      (chr_addr),
    .chr_data      (chr_data),
    .rgb           (rgb),
    .hsync         (hsync),
    .vsync         (vsync)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vid_data <= ram[vid_addr];
    chr_data <= rom[chr_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start(input logic [3:0] mode);
    graphics_mode = mode;
    x_in = '0; y_in = '0; active_in = 1'b0;
    step();
  endtask

  task automatic line_start(input int y);
    x_in = '0; y_in = 10'(y); active_in = 1'b0;
    step();
  endtask

  // cap[k]/ca[k]/va[k] hold rgb/chr_addr/vid_addr derived from pixel x0+k
  task automatic run_x(input int y, input int x0, input int n);
    for (int i = 0; i < n + 4; i++) begin
      x_in = 10'(x0 + i); y_in = 10'(y); active_in = 1'b1;
      step();
      va[i] = vid_addr;
      if (i >= 2) ca[i-2] = chr_addr;
      if (i >= 4) cap[i-4] = rgb;
    end
    active_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    checks++; if (rgb !== BLK) begin errors++; $display("FAIL reset_rgb: got %h want %h", rgb, BLK); end
    checks++; if (hsync !== 1'b0 || vsync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b%b want 00", hsync, vsync); end
    checks++; if (vid_addr !== 13'd0) begin errors++; $display("FAIL reset_vid_addr: got %h want 0", vid_addr); end
    checks++; if (chr_addr !== 10'd0) begin errors++; $display("FAIL reset_chr_addr: got %h want 0", chr_addr); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_text();
    ram[0] = 8'h01; rom[10'h010] = 8'h80;
    frame_start(4'h0);
    line_start(48);
    run_x(48, 64, 16);
    checks++; if (va[0] !== 13'd0) begin errors++; $display("FAIL text_vid_addr: got %h want 0", va[0]); end
    checks++; if (ca[0] !== 10'h010) begin errors++; $display("FAIL text_chr_addr: got %h want 010", ca[0]); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== ((k < 2) ? GRN : BLK)) begin
        errors++; $display("FAIL text_pixel x=%0d: got %h want %h", 64 + k, cap[k], (k < 2) ? GRN : BLK);
      end
    end
  endtask

  task automatic test_inverse();
    ram[0] = 8'h81;
    frame_start(4'h0);
    line_start(48);
    run_x(48, 64, 16);
    checks++; if (ca[0] !== 10'h010) begin errors++; $display("FAIL inv_chr_addr: got %h want 010", ca[0]); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== ((k < 2) ? BLK : GRN)) begin
        errors++; $display("FAIL inv_pixel x=%0d: got %h want %h", 64 + k, cap[k], (k < 2) ? BLK : GRN);
      end
    end
  endtask

  task automatic test_mode7();
    ram[32] = 8'hAA;
    frame_start(4'hF);
    line_start(48); line_start(49); line_start(50);
    run_x(50, 64, 16);
    checks++; if (va[0] !== 13'd32) begin errors++; $display("FAIL m7_vid_addr: got %0d want 32", va[0]); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== (((k / 2) % 2 == 0) ? GRN : BLK)) begin
        errors++; $display("FAIL m7_pixel x=%0d: got %h want %h", 64 + k, cap[k], ((k / 2) % 2 == 0) ? GRN : BLK);
      end
    end
  endtask

  task automatic test_mode0();
    logic [8:0] runs [4];
    runs[0] = GRN; runs[1] = YEL; runs[2] = BLU; runs[3] = RED;
    ram[0] = 8'h1B;
    frame_start(4'h1);
    for (int y = 48; y <= 54; y++) begin
      line_start(y);
      run_x(y, 64, (y == 48) ? 32 : 1);
      checks++;
      if (va[0] !== ((y == 54) ? 13'd16 : 13'd0)) begin
        errors++; $display("FAIL m0_vid_addr y=%0d: got %0d want %0d", y, va[0], (y == 54) ? 16 : 0);
      end
      if (y == 48) begin
        for (int k = 0; k < 32; k++) begin
          checks++;
          if (cap[k] !== runs[k / 8]) begin
            errors++; $display("FAIL m0_pixel x=%0d: got %h want %h", 64 + k, cap[k], runs[k / 8]);
          end
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    ram[0] = 8'h01;
    frame_start(4'h0);
    graphics_mode = 4'hF;
    line_start(48);
    run_x(48, 64, 16);
    checks++; if (cap[0] !== GRN) begin errors++; $display("FAIL sw_old_first: got %h want %h", cap[0], GRN); end
    checks++; if (cap[14] !== BLK) begin errors++; $display("FAIL sw_old_last: got %h want %h", cap[14], BLK); end
    frame_start(4'hF);
    line_start(48);
    run_x(48, 64, 16);
    checks++; if (cap[0] !== BLK) begin errors++; $display("FAIL sw_new_first: got %h want %h", cap[0], BLK); end
    checks++; if (cap[14] !== GRN) begin errors++; $display("FAIL sw_new_last: got %h want %h", cap[14], GRN); end
    run_x(48, 40, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap[k] !== BLK) begin errors++; $display("FAIL border_rgb x=%0d: got %h want 0", 40 + k, cap[k]); end
    end
    checks++; if (va[3] !== 13'd1) begin errors++; $display("FAIL border_hold_addr: got %0d want 1", va[3]); end
  endtask

  task automatic test_reset_midline();
    logic [15:0] pat;
    pat = 16'hB36D;
    ram[0] = 8'h01;
    frame_start(4'h0);
    line_start(48);
    hs_in = 1'b1; vs_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x_in = 10'(64 + i); y_in = 10'd48; active_in = 1'b1;
      step();
    end
    checks++; if (rgb !== GRN) begin errors++; $display("FAIL pre_reset_rgb: got %h want %h", rgb, GRN); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL pre_reset_hsync: got %b want 1", hsync); end
    reset = 1'b0;
    #1;
    checks++; if (rgb !== BLK) begin errors++; $display("FAIL midreset_rgb: got %h want 0", rgb); end
    checks++; if (hsync !== 1'b0 || vsync !== 1'b0) begin errors++; $display("FAIL midreset_sync: got %b%b want 00", hsync, vsync); end
    checks++; if (vid_addr !== 13'd0 || chr_addr !== 10'd0) begin errors++; $display("FAIL midreset_addr: got %h/%h want 0/0", vid_addr, chr_addr); end
    reset = 1'b1;
    active_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      hs_in = pat[i]; vs_in = ~pat[i];
      step();
      checks++;
      if (hsync !== ((i >= 4) ? pat[i-4] : 1'b0) || vsync !== ((i >= 4) ? ~pat[i-4] : 1'b0)) begin
        errors++; $display("FAIL sync_delay i=%0d: got %b%b want %b%b", i, hsync, vsync,
                           (i >= 4) ? pat[i-4] : 1'b0, (i >= 4) ? ~pat[i-4] : 1'b0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    test_reset();
    test_text();
    test_inverse();
    test_mode7();
    test_mode0();
    test_mode_switch();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
